// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: final stage of the drawing pipeline. Bounds-checks one
// pixel per cycle, turns (x,y) into a linear framebuffer address, queues it
// in a small FIFO, and drains the FIFO through the shared framebuffer write
// port whenever scan-out grants that port.
//
// Handshake: the upstream request (pix_valid) is taken on an edge where
// pix_valid && pix_ready. pix_ready depends only on registered state, so it
// never depends on pix_valid. A request raised while pix_ready is low is
// dropped and leaves a sticky overflow flag. On the framebuffer side, fb_we
// is a one-cycle write strobe: each cycle it is high, the head entry is
// written and popped.
module fb_pixel_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [2:0]        pix_color,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic              pix_ready,
  input  logic              fb_grant,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 3;

  // Stage A register
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_color;

  // FIFO storage and bookkeeping
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;

  // Value shown on the port while the FIFO is empty
  logic [ADDR_W-1:0] last_addr;
  logic [2:0]        last_data;

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] pix_addr;
  logic              empty;
  logic              push;
  logic              pop;
  logic [CW:0]       occupancy;

  // Address is formed at full ADDR_W width so (H_RES-1,V_RES-1) never truncates.
  assign in_range  = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
  assign pix_addr  = ADDR_W'(pix_y) * ADDR_W'(H_RES) + ADDR_W'(pix_x);

  // Stage A counts as occupied so an accepted pixel always has a FIFO slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, a_valid};
  assign pix_ready = occupancy < (CW+1)'(DEPTH);
  assign accept    = pix_valid && pix_ready;

  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign push      = a_valid;
  assign pop       = fb_we;

  assign fb_we     = !empty && fb_grant;
  assign fb_addr   = empty ? last_addr : head[EW-1:3];
  assign fb_data   = empty ? last_data : head[2:0];
  assign busy      = a_valid || !empty;

  // Stage A: capture in-range accepted pixels with their linear address.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_color <= '0;
    end else begin
      a_valid <= accept && in_range;
      if (accept && in_range) begin
        a_addr  <= pix_addr;
        a_color <= pix_color;
      end
    end
  end

  // Status: sticky overflow on rejected requests, saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (pix_valid && !pix_ready) overflow <= 1'b1;
      if (accept && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // FIFO storage write; contents need no reset because count gates all reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {a_addr, a_color};
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the last written entry so the port holds it while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr <= '0;
      last_data <= '0;
    end else if (pop) begin
      last_addr <= head[EW-1:3];
      last_data <= head[2:0];
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed vectors, expected writes pushed into a
// queue by the driver, popped and compared by a monitor on every fb_we.
module tb_fb_pixel_writer;

  localparam int ADDR_W = 19;
  localparam int EW     = ADDR_W + 3;

  logic              clk;
  logic              rst;
  logic              pix_valid;
  logic [2:0]        pix_color;
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic              pix_ready;
  logic              fb_grant;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [2:0]        fb_data;
  logic              busy;
  logic              overflow;
  logic [7:0]        drop_count;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int run_len = 0;
  int max_run = 0;

  fb_pixel_writer #(.H_RES(640), .V_RES(480), .DEPTH(8), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_color(pix_color), .pix_x(pix_x), .pix_y(pix_y),
    .pix_ready(pix_ready), .fb_grant(fb_grant),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] entry(input int x, input int y, input int c);
    int a;
    a = y * 640 + x;
    return {a[ADDR_W-1:0], c[2:0]};
  endfunction

  // Driver: present one pixel for one cycle; push expectation if told it lands.
  task automatic send_pix(input int x, input int y, input int c, input bit expect_write);
    pix_valid = 1'b1;
    pix_x     = x[9:0];
    pix_y     = y[9:0];
    pix_color = c[2:0];
    if (expect_write) exp_q.push_back(entry(x, y, c));
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  // Monitor / scoreboard: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && fb_we) begin
      logic [EW-1:0] e;
      wr_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0d data %0d with empty queue", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", fb_addr, e[EW-1:3]);
        check("wr_data", fb_data, e[2:0]);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    int w0;
    rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0; fb_grant = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ready", pix_ready, 1);

    // Single pixel: (5,2) -> 1285, colour 6, two-cycle latency, one pulse
    fb_grant = 1'b1;
    w0 = wr_cnt;
    send_pix(5, 2, 6, 1'b1);
    check("single_lat1_we", fb_we, 0);
    tick();
    check("single_we", fb_we, 1);
    check("single_addr", fb_addr, 1285);
    check("single_data", fb_data, 6);
    tick();
    check("single_we_off", fb_we, 0);
    check("single_busy", busy, 0);
    check("single_hold_addr", fb_addr, 1285);
    check("single_pulses", wr_cnt - w0, 1);

    // Corner bounds
    exp_q.push_back({19'd307199, 3'd5});
    send_pix(639, 479, 5, 1'b0);
    send_pix(640, 0, 1, 1'b0);
    send_pix(0, 480, 2, 1'b0);
    wait_drain("corner_drain", 10);
    tick(); tick();
    check("corner_drop", drop_count, 2);
    check("corner_overflow", overflow, 0);
    check("corner_busy", busy, 0);

    // Burst with stall: 8 accepted, 4 rejected
    fb_grant = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("burst_ready_%0d", i), pix_ready, (i < 8) ? 1 : 0);
      send_pix(10 + i, 3, i % 8, i < 8);
      if (i == 8) check("burst_overflow", overflow, 1);
    end
    tick(); tick();
    check("burst_busy", busy, 1);
    check("burst_we_stalled", fb_we, 0);
    fb_grant = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("burst_b2b_%0d", i), fb_we, 1);
      tick();
    end
    check("burst_we_done", fb_we, 0);
    check("burst_ready_back", pix_ready, 1);
    wait_drain("burst_drain", 4);

    // Streaming 96 pixels at full rate
    max_run = 0;
    w0 = wr_cnt;
    begin
      int not_ready = 0;
      for (int i = 0; i < 96; i++) begin
        if (!pix_ready) not_ready++;
        send_pix(i * 6, 100 + i, i % 8, 1'b1);
      end
      check("stream_ready_low_cycles", not_ready, 0);
    end
    wait_drain("stream_drain", 10);
    check("stream_writes", wr_cnt - w0, 96);
    check("stream_run", max_run, 96);

    // Intermittent grant
    w0 = wr_cnt;
    begin
      int not_ready = 0;
      for (int i = 0; i < 10; i++) begin
        fb_grant = ~fb_grant;
        if (!pix_ready) not_ready++;
        send_pix(300 + i, 200 + i, (i + 3) % 8, 1'b1);
      end
      check("toggle_ready_low_cycles", not_ready, 0);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      fb_grant = ~fb_grant;
      tick();
    end
    check("toggle_drain", exp_q.size(), 0);
    check("toggle_writes", wr_cnt - w0, 10);

    // Reset mid-burst with 5 pending entries
    fb_grant = 1'b0;
    for (int i = 0; i < 5; i++) send_pix(50 + i, 60, i, 1'b0);
    check("mid_busy", busy, 1);
    w0 = wr_cnt;
    rst = 1'b1;
    tick();
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_ready", pix_ready, 1);
    rst = 1'b0;
    fb_grant = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("mid_no_stale", wr_cnt - w0, 0);
    send_pix(1, 1, 7, 1'b1);
    wait_drain("post_rst_drain", 10);
    check("post_rst_writes", wr_cnt - w0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
